// File: rtl/mem_stage_if.sv
// Bundle of the EXE/MEM -> MEM/WB signals of the memory stage.
// The fwd* forwarding taps exist only when MEM_FWD_EN is defined.
interface mem_stage_if;
    logic       regWr_IN;
    logic       memWr_IN;
    logic       memRd_IN;
    logic [7:0] aluRes_IN;
    logic [7:0] memWrData_IN;
    logic [2:0] rd_IN;
    logic       stall;
    logic       regWr_OUT;
    logic [2:0] rd_OUT;
    logic [7:0] wbData_OUT;
`ifdef MEM_FWD_EN
    logic       fwdValid;
    logic [2:0] fwdRd;
    logic [7:0] fwdData;

    modport master (
        output regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN,
        input  stall, regWr_OUT, rd_OUT, wbData_OUT, fwdValid, fwdRd, fwdData
    );
    modport slave (
        input  regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN,
        output stall, regWr_OUT, rd_OUT, wbData_OUT, fwdValid, fwdRd, fwdData
    );
`else
    modport master (
        output regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN,
        input  stall, regWr_OUT, rd_OUT, wbData_OUT
    );
    modport slave (
        input  regWr_IN, memWr_IN, memRd_IN, aluRes_IN, memWrData_IN, rd_IN,
        output stall, regWr_OUT, rd_OUT, wbData_OUT
    );
`endif
endinterface

// File: rtl/mem_stage.sv
// Memory stage: 256x8 data memory with MEM_LAT wait states, stalls upstream while busy.
// Optional macro MEM_FWD_EN adds the fwdValid/fwdRd/fwdData forwarding taps.
module mem_stage #(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;
    localparam logic [2:0] LAT_LOAD = (MEM_LAT > 0) ? 3'(MEM_LAT - 1) : 3'd0;
    localparam logic       LAT_NZ   = (MEM_LAT != 0);

    logic [0:0] r_state;
    logic [2:0] r_cnt;
    logic [7:0] r_mem [256];
    logic       r_reg_wr;
    logic [2:0] r_rd;
    logic [7:0] r_wb_data;

    logic       w_acc;
    logic       w_stall;
    logic [7:0] w_rd_data;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_acc     = bus.memRd_IN | bus.memWr_IN;
        w_rd_data = r_mem[bus.aluRes_IN];
        w_stall   = 1'b0;
        if (r_state == S_IDLE) w_stall = w_acc & LAT_NZ;
        else                   w_stall = (r_cnt != 3'd0);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                S_IDLE: if (w_acc && LAT_NZ) begin
                    r_cnt   <= LAT_LOAD;
                    r_state <= S_WAIT;
                end
                S_WAIT: if (r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
                        else               r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A stalled edge inserts a bubble; rd/data hold their last completed values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reg_wr  <= 1'b0;
            r_rd      <= 3'd0;
            r_wb_data <= 8'd0;
        end else if (!w_stall) begin
            r_reg_wr  <= bus.regWr_IN;
            r_rd      <= bus.rd_IN;
            r_wb_data <= w_acc ? w_rd_data : bus.aluRes_IN;
        end else begin
            r_reg_wr  <= 1'b0;
        end
    end

    // NOTE: the memory array really is cleared on reset, so it lives in flops, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) r_mem[i] <= 8'd0;
        end else if (!w_stall && bus.memWr_IN) begin
            r_mem[bus.aluRes_IN] <= bus.memWrData_IN;
        end
    end

    assign bus.stall      = w_stall;
    assign bus.regWr_OUT  = r_reg_wr;
    assign bus.rd_OUT     = r_rd;
    assign bus.wbData_OUT = r_wb_data;

`ifdef MEM_FWD_EN
    assign bus.fwdValid = r_reg_wr & (r_rd != 3'd0);
    assign bus.fwdRd    = r_rd;
    assign bus.fwdData  = r_wb_data;
`endif
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 8-bit pipelined datapath. It consumes the EXE/MEM pipeline register outputs and performs data-memory loads and stores against an internal 256x8 data memory with a configurable number of wait states. It drives the MEM/WB pipeline register outputs toward write-back, and it raises a stall toward the upstream stages while a memory access is in progress.

## Interface
Parameters:
- MEM_LAT, default 2: wait cycles per memory access, legal range 0..7. A memory access takes MEM_LAT+1 cycles in the stage.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- regWr_IN  in  1  register write enable from EXE/MEM
- memWr_IN  in  1  store request
- memRd_IN  in  1  load request
- aluRes_IN  in  8  ALU result; memory address for loads/stores
- memWrData_IN  in  8  store data
- rd_IN  in  3  destination register
- stall  out  1  combinational; upstream stages and EXE/MEM must hold while high
- regWr_OUT  out  1  MEM/WB register write enable
- rd_OUT  out  3  MEM/WB destination register
- wbData_OUT  out  8  MEM/WB write-back data

## Operation
- Data memory is mem[0..255], 8 bits per entry, addressed by aluRes_IN. All entries clear to 0 on rst.
- The access signal is defined as acc = memRd_IN | memWr_IN.
- FSM states:
  - IDLE:
    - If acc=1 and MEM_LAT>0: load cnt = MEM_LAT-1 and move to WAIT.
    - Otherwise: complete the access this cycle and stay in IDLE.
  - WAIT:
    - If cnt!=0: decrement cnt.
    - If cnt==0: complete the access and move to IDLE.
- stall = (IDLE & acc & MEM_LAT!=0) | (WAIT & cnt!=0).
- Completion (the only edge with stall=0 for the instruction):
  - If memWr_IN=1: mem[aluRes_IN] <= memWrData_IN.
  - wbData_OUT <= mem[aluRes_IN] if acc=1, else aluRes_IN. Reads are read-before-write.
  - regWr_OUT <= regWr_IN and rd_OUT <= rd_IN.
- Simultaneous memRd_IN and memWr_IN: the store is performed and wbData_OUT receives the old memory content.
- Stalled edges: regWr_OUT <= 0 (bubble). rd_OUT and wbData_OUT hold. Memory is not written.
- While stall=1, inputs must be held stable by upstream. The block does not latch inputs at access start.
- Non-memory instructions (acc=0) never stall, in any MEM_LAT configuration.

## Timing
- Reset values: state=IDLE, cnt=0, regWr_OUT=0, rd_OUT=0, wbData_OUT=0. stall is 0 unless acc is presented in IDLE.
- Latency:
  - Non-memory instruction: MEM/WB outputs are valid 1 edge after presentation.
  - Memory instruction: outputs are valid MEM_LAT+1 edges after presentation.
  - stall is high for exactly MEM_LAT cycles per access.
- MEM_LAT=0: the FSM never leaves IDLE, stall is constant 0, and every instruction is single-cycle.
- Back-to-back accesses: the completion edge returns the FSM to IDLE. The next access starts its stall in the immediately following cycle, with no dead cycle between accesses.
- Reset mid-access: the FSM aborts to IDLE with no memory write performed. If acc is still present after reset, the access restarts from the full count.
- cnt is 3 bits wide and cannot wrap, because it is loaded with at most 6.

## Configuration
- MEM_FWD_EN defined:
  - Adds outputs fwdValid (1 bit), fwdRd (3 bits) and fwdData (8 bits).
  - These are combinational copies of regWr_OUT, rd_OUT and wbData_OUT, for the EXE-stage forwarding unit.
  - fwdValid is forced to 0 whenever rd_OUT==0.
- MEM_FWD_EN undefined: the ports do not exist and no forwarding logic is built. All other behaviour is identical.

## Test plan
- Reset: assert rst mid-WAIT (MEM_LAT=2) -> all outputs 0, stall 0 with acc=0, target memory byte unchanged (reads 0 afterwards).
- ALU pass-through: regWr=1, rd=3, aluRes=0x5A, acc=0 -> next edge regWr_OUT=1, rd_OUT=3, wbData_OUT=0x5A, stall never high.
- Store then load (MEM_LAT=2):
  - Store 0xC3 to address 0x10 -> stall high for 2 cycles, regWr_OUT=0 throughout, memory written on the 3rd edge.
  - Load from 0x10, rd=5 -> wbData_OUT=0xC3, rd_OUT=5 after 3 edges.
- Read-before-write: mem[0x20]=0x11, then memRd=memWr=1 with data 0x22 -> wbData_OUT=0x11, and a subsequent load returns 0x22.
- MEM_LAT=0: alternating store and load at address 0xFF -> stall constantly 0 and the load returns the stored value 1 edge later.
- MEM_FWD_EN: load into rd=0 -> fwdValid=0. ALU op with rd=6, result 0x7E -> fwdValid=1, fwdRd=6, fwdData=0x7E.
